// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue front-end: ALU select codes,
// select width and a legality helper used when screening requests.
package alu_issue_pkg;

  localparam int ALU_SELW = 4;

  localparam logic [ALU_SELW-1:0] ALU_OP_ADD  = 4'd0;
  localparam logic [ALU_SELW-1:0] ALU_OP_SUB  = 4'd1;
  localparam logic [ALU_SELW-1:0] ALU_OP_MUL  = 4'd2;
  localparam logic [ALU_SELW-1:0] ALU_OP_DIV  = 4'd3;
  localparam logic [ALU_SELW-1:0] ALU_OP_AND  = 4'd4;
  localparam logic [ALU_SELW-1:0] ALU_OP_OR   = 4'd5;
  localparam logic [ALU_SELW-1:0] ALU_OP_XOR  = 4'd6;
  localparam logic [ALU_SELW-1:0] ALU_OP_GEU  = 4'd7;
  localparam logic [ALU_SELW-1:0] ALU_OP_LTU  = 4'd8;
  localparam logic [ALU_SELW-1:0] ALU_OP_EQ   = 4'd9;
  localparam logic [ALU_SELW-1:0] ALU_OP_NE   = 4'd10;
  localparam logic [ALU_SELW-1:0] ALU_OP_LAST = 4'd10;

  // Codes above ALU_OP_LAST have no ALU meaning and are answered locally.
  function automatic logic op_is_legal(input logic [ALU_SELW-1:0] op);
    return (op <= ALU_OP_LAST);
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Request/response bundle between the EXU decode logic (master) and the
// ALU issue front-end (slave).
// Handshake: a transfer happens on a rising clock edge where valid && ready
// are both high; the sender holds its payload stable while valid && !ready,
// and ready never depends combinationally on the partner's valid.
interface alu_issue_if #(
  parameter int N    = 64,
  parameter int TAGW = 4
);
  import alu_issue_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [ALU_SELW-1:0] req_op;
  logic [N-1:0]        req_a;
  logic [N-1:0]        req_b;
  logic [TAGW-1:0]     req_tag;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [N-1:0]        rsp_res;
  logic [TAGW-1:0]     rsp_tag;
  logic                rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag,
    input  req_ready,
    input  rsp_valid, rsp_res, rsp_tag, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag,
    output req_ready,
    output rsp_valid, rsp_res, rsp_tag, rsp_err,
    input  rsp_ready
  );

endinterface

// File: rtl/alu_rsp_fifo.sv
// Response buffer for the ALU issue front-end: DEPTH entries of W bits,
// power-of-two depth so the pointers wrap naturally, occupancy exposed.
module alu_rsp_fifo #(
  parameter int W     = 69,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // A pop on empty is dropped; a push on full is taken only alongside a pop.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != (PW+1)'(DEPTH)) || do_pop);

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers and storage; storage clears so the
  // response data outputs read zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/alu_issue.sv
// ALU issue front-end: registers tagged requests into a single stage (S1)
// that feeds the external combinational ALU, screens divide-by-zero and
// illegal select codes, and buffers tagged results in a response FIFO.
// Optional statistics counters are built when ALU_ISSUE_STATS_EN is defined.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int N     = 64,
  parameter int TAGW  = 4,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  alu_issue_if.slave          bus,
  output logic [N-1:0]        alu_a,
  output logic [N-1:0]        alu_b,
  output logic [ALU_SELW-1:0] alu_sel,
  input  logic [N-1:0]        alu_res
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]         stat_issued,
  output logic [31:0]         stat_errs
`endif
);

  localparam int CNTW = $clog2(DEPTH) + 1;
  localparam int EW   = N + TAGW + 1;

  // S1 stage registers.
  logic                s1_valid_q, s1_valid_d;
  logic [ALU_SELW-1:0] s1_op_q,    s1_op_d;
  logic [ALU_SELW-1:0] s1_sel_q,   s1_sel_d;
  logic [N-1:0]        s1_a_q,     s1_a_d;
  logic [N-1:0]        s1_b_q,     s1_b_d;
  logic [TAGW-1:0]     s1_tag_q,   s1_tag_d;

  logic                req_fire;
  logic [CNTW-1:0]     fifo_count;
  logic [CNTW-1:0]     credit_used;

  logic                s1_div0;
  logic                s1_illegal;
  logic [N-1:0]        s1_res;
  logic                s1_err;

  logic [EW-1:0]       fifo_wdata;
  logic [EW-1:0]       fifo_rdata;
  logic                fifo_valid;
  logic                rsp_pop;

  // Credits count both buffered entries and the one in flight in S1, so a
  // newly accepted request always finds a FIFO slot and S1 never stalls.
  // Same-cycle pops are deliberately ignored: no path from rsp_ready.
  assign credit_used   = fifo_count + CNTW'(s1_valid_q);
  assign bus.req_ready = (credit_used < CNTW'(DEPTH));
  assign req_fire      = bus.req_valid && bus.req_ready;

  // S1 load: capture on accept, otherwise hold operands so the ALU inputs
  // stay quiet; illegal codes are sent to the ALU as select 0.
  always_comb begin
    s1_valid_d = req_fire;
    s1_op_d    = s1_op_q;
    s1_sel_d   = s1_sel_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    if (req_fire) begin
      s1_op_d  = bus.req_op;
      s1_sel_d = op_is_legal(bus.req_op) ? bus.req_op : '0;
      s1_a_d   = bus.req_a;
      s1_b_d   = bus.req_b;
      s1_tag_d = bus.req_tag;
    end
  end

  // S1 register; reset drops any in-flight request and zeroes ALU inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_sel_q   <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_sel_q   <= s1_sel_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tag_q   <= s1_tag_d;
    end
  end

  assign alu_a   = s1_a_q;
  assign alu_b   = s1_b_q;
  assign alu_sel = s1_sel_q;

  assign s1_div0    = (s1_op_q == ALU_OP_DIV) && (s1_b_q == '0);
  assign s1_illegal = !op_is_legal(s1_op_q);

  // Result screening: illegal codes answer 0, divide-by-zero answers
  // all-ones, everything else passes the ALU result through.
  always_comb begin
    s1_res = alu_res;
    s1_err = 1'b0;
    if (s1_illegal) begin
      s1_res = '0;
      s1_err = 1'b1;
    end else if (s1_div0) begin
      s1_res = '1;
      s1_err = 1'b1;
    end
  end

  assign fifo_wdata = {s1_res, s1_tag_q, s1_err};
  assign rsp_pop    = fifo_valid && bus.rsp_ready;

  alu_rsp_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (s1_valid_q),
    .wdata_i (fifo_wdata),
    .pop_i   (rsp_pop),
    .rdata_o (fifo_rdata),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign bus.rsp_valid = fifo_valid;
  assign bus.rsp_res   = fifo_rdata[EW-1 -: N];
  assign bus.rsp_tag   = fifo_rdata[TAGW:1];
  assign bus.rsp_err   = fifo_rdata[0];

`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] stat_issued_q, stat_issued_d;
  logic [31:0] stat_errs_q,   stat_errs_d;

  // Counter increments: accepted requests and error results; wrap freely.
  always_comb begin
    stat_issued_d = stat_issued_q;
    stat_errs_d   = stat_errs_q;
    if (req_fire)            stat_issued_d = stat_issued_q + 32'd1;
    if (s1_valid_q && s1_err) stat_errs_d  = stat_errs_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued_q <= '0;
      stat_errs_q   <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_errs_q   <= stat_errs_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_errs   = stat_errs_q;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue with a behavioural ALU attached to the alu_* ports.
module tb_alu_issue;
  import alu_issue_pkg::*;

  localparam int N     = 64;
  localparam int TAGW  = 4;
  localparam int DEPTH = 4;
  localparam int EW    = N + TAGW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_if #(.N(N), .TAGW(TAGW)) bus ();

  logic [N-1:0]        alu_a, alu_b, alu_res;
  logic [ALU_SELW-1:0] alu_sel;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] stat_issued, stat_errs;
`endif

  alu_issue #(.N(N), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_sel (alu_sel),
    .alu_res (alu_res)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_errs   (stat_errs)
`endif
  );

  // Behavioural shared ALU.
  always_comb begin
    alu_res = '0;
    case (alu_sel)
      ALU_OP_ADD: alu_res = alu_a + alu_b;
      ALU_OP_SUB: alu_res = alu_a - alu_b;
      ALU_OP_MUL: alu_res = alu_a * alu_b;
      ALU_OP_DIV: alu_res = (alu_b != '0) ? alu_a / alu_b : '1;
      ALU_OP_AND: alu_res = alu_a & alu_b;
      ALU_OP_OR:  alu_res = alu_a | alu_b;
      ALU_OP_XOR: alu_res = alu_a ^ alu_b;
      ALU_OP_GEU: alu_res = N'(alu_a >= alu_b);
      ALU_OP_LTU: alu_res = N'(alu_a < alu_b);
      ALU_OP_EQ:  alu_res = N'(alu_a == alu_b);
      ALU_OP_NE:  alu_res = N'(alu_a != alu_b);
      default:    alu_res = '0;
    endcase
  end

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  int rsp_seen     = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake is compared against the queue head.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      logic [EW-1:0] e;
      rsp_seen++;
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL rsp_unexpected: got res=0x%0h tag=%0d with no response outstanding",
                 bus.rsp_res, bus.rsp_tag);
      end else begin
        e = exp_q.pop_front();
        check("rsp_res", bus.rsp_res, e[EW-1 -: N]);
        check("rsp_tag", N'(bus.rsp_tag), N'(e[TAGW:1]));
        check("rsp_err", N'(bus.rsp_err), N'(e[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [ALU_SELW-1:0] op, input logic [N-1:0] a,
                      input logic [N-1:0] b, input logic [TAGW-1:0] tag,
                      input logic [N-1:0] exp_res, input logic exp_err,
                      output int waits);
    waits = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    @(negedge clk);
    while (!bus.req_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!bus.req_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL req_accept_timeout: req_ready=0 for %0d cycles, required 1", waits);
    end else begin
      exp_q.push_back({exp_res, tag, exp_err});
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, N'(exp_q.size()), '0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct packed {
    logic [ALU_SELW-1:0] op;
    logic [N-1:0]        a;
    logic [N-1:0]        b;
    logic [N-1:0]        res;
    logic                err;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{ALU_OP_SUB, 64'd9,    64'd4,    64'd5,    1'b0};
    vecs[1]  = '{ALU_OP_AND, 64'd9,    64'd4,    64'd0,    1'b0};
    vecs[2]  = '{ALU_OP_LTU, 64'd9,    64'd4,    64'd0,    1'b0};
    vecs[3]  = '{ALU_OP_MUL, 64'd6,    64'd7,    64'd42,   1'b0};
    vecs[4]  = '{ALU_OP_DIV, 64'd100,  64'd7,    64'd14,   1'b0};
    vecs[5]  = '{ALU_OP_OR,  64'hF0,   64'h0F,   64'hFF,   1'b0};
    vecs[6]  = '{ALU_OP_XOR, 64'hFF,   64'h0F,   64'hF0,   1'b0};
    vecs[7]  = '{ALU_OP_GEU, 64'd3,    64'd3,    64'd1,    1'b0};
    vecs[8]  = '{ALU_OP_EQ,  64'd5,    64'd5,    64'd1,    1'b0};
    vecs[9]  = '{ALU_OP_NE,  64'd5,    64'd5,    64'd0,    1'b0};
    vecs[10] = '{ALU_OP_SUB, 64'd0,    64'd1,    64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int w;
    int stall;
    int k;
    int seen_before;

    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_req_ready", N'(bus.req_ready), N'(1'b1));
    check("rst_rsp_valid", N'(bus.rsp_valid), '0);
    check("rst_alu_a",     alu_a, '0);
    check("rst_alu_b",     alu_b, '0);
    check("rst_alu_sel",   N'(alu_sel), '0);
    check("rst_rsp_res",   bus.rsp_res, '0);
    check("rst_rsp_tag",   N'(bus.rsp_tag), '0);
    check("rst_rsp_err",   N'(bus.rsp_err), '0);
    @(posedge clk);
    #1;

    // Scenario 1: single add, latency check.
    bus.rsp_ready = 1'b1;
    send(ALU_OP_ADD, 64'd5, 64'd7, 4'd3, 64'd12, 1'b0, w);
    check("s1_rsp_valid_early", N'(bus.rsp_valid), '0);
    check("s1_alu_a",   alu_a, 64'd5);
    check("s1_alu_b",   alu_b, 64'd7);
    check("s1_alu_sel", N'(alu_sel), N'(ALU_OP_ADD));
    @(posedge clk);
    #1;
    check("s1_rsp_valid_lat", N'(bus.rsp_valid), N'(1'b1));
    wait_drain("s1_drain");

    // Scenario 2: back-to-back vectors, no stall expected.
    stall = 0;
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, TAGW'(i), vecs[i].res, vecs[i].err, w);
      stall += w;
    end
    check("s2_no_stall", N'(stall), '0);
    wait_drain("s2_drain");

    // Scenario 3: screening.
    send(ALU_OP_DIV, 64'd10, 64'd0, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, w);
    check("s3_div_sel", N'(alu_sel), N'(ALU_OP_DIV));
    send(4'd13, 64'd1, 64'd2, 4'd5, 64'd0, 1'b1, w);
    check("s3_illegal_sel", N'(alu_sel), '0);
    send(4'd11, 64'd3, 64'd4, 4'd6, 64'd0, 1'b1, w);
    check("s3_op11_sel", N'(alu_sel), '0);
    wait_drain("s3_drain");

    // Scenario 4: backpressure fills exactly DEPTH credits.
    bus.rsp_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      bus.req_valid = 1'b1;
      bus.req_op    = ALU_OP_ADD;
      bus.req_a     = N'(k);
      bus.req_b     = 64'd100;
      bus.req_tag   = TAGW'(k);
      @(negedge clk);
      if (bus.req_ready) begin
        exp_q.push_back({N'(k + 100), TAGW'(k), 1'b0});
        k++;
      end
      @(posedge clk);
      #1;
    end
    check("s4_accepted", N'(k), N'(DEPTH));
    check("s4_req_ready_low", N'(bus.req_ready), '0);
    check("s4_rsp_valid", N'(bus.rsp_valid), N'(1'b1));
    check("s4_head_res", bus.rsp_res, 64'd100);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("s4_hold_res", bus.rsp_res, 64'd100);
    check("s4_hold_tag", N'(bus.rsp_tag), '0);
    check("s4_hold_ready_low", N'(bus.req_ready), '0);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_drain("s4_drain");
    @(negedge clk);
    check("s4_req_ready_back", N'(bus.req_ready), N'(1'b1));
    @(posedge clk);
    #1;

    // Scenario 5: reset with two FIFO entries and S1 occupied.
    bus.rsp_ready = 1'b0;
    send(ALU_OP_ADD, 64'd1, 64'd1, 4'd1, 64'd2, 1'b0, w);
    send(ALU_OP_ADD, 64'd2, 64'd2, 4'd2, 64'd4, 1'b0, w);
    send(ALU_OP_ADD, 64'd3, 64'd3, 4'd3, 64'd6, 1'b0, w);
    check("s5_pre_rst_valid", N'(bus.rsp_valid), N'(1'b1));
    rst = 1'b1;
    exp_q.delete();
    seen_before = rsp_seen;
    bus.req_valid = 1'b1;
    bus.req_op    = ALU_OP_ADD;
    bus.req_a     = 64'd7;
    bus.req_b     = 64'd7;
    bus.req_tag   = 4'd9;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("s5_req_ready", N'(bus.req_ready), N'(1'b1));
    check("s5_rsp_valid", N'(bus.rsp_valid), '0);
    check("s5_alu_a", alu_a, '0);
    bus.rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("s5_no_rsp", N'(rsp_seen - seen_before), '0);

`ifdef ALU_ISSUE_STATS_EN
    // Scenario 6: statistics after scenarios 1 and 3 from a fresh reset.
    send(ALU_OP_ADD, 64'd5, 64'd7, 4'd3, 64'd12, 1'b0, w);
    send(ALU_OP_DIV, 64'd10, 64'd0, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, w);
    send(4'd13, 64'd1, 64'd2, 4'd5, 64'd0, 1'b1, w);
    wait_drain("s6_drain");
    check("s6_stat_issued", N'(stat_issued), 64'd3);
    check("s6_stat_errs",   N'(stat_errs),   64'd2);
`endif

    wait_drain("final_drain");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
